// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared types and constants for the ULPI transmit path.
//   ulpi_arb_state_t  : TX arbiter ownership state (idle / packet / register)
//   ULPI_TX_CMD_REGW  : TX CMD prefix for an immediate register write
//   ULPI_TX_CMD_REGR  : TX CMD prefix for an immediate register read
package ulpi_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PKT  = 2'd1,
        S_REG  = 2'd2
    } ulpi_arb_state_t;

    // Upper two bits of the TX CMD byte; the low six bits carry the address.
    localparam logic [7:0] ULPI_TX_CMD_REGW = 8'h80;
    localparam logic [7:0] ULPI_TX_CMD_REGR = 8'hC0;

endpackage

// File: rtl/ulpi_tx_arbiter.sv
// ulpi_tx_arbiter: shares the ULPI TX stream between the link-layer packet
// transmitter (pkt_*) and the PHY register-access controller (reg_*).
// A grant is taken only in idle while the PHY is not driving the bus, and is
// held from the first beat until the accepted tlast beat; one idle bubble
// separates consecutive transfers.
//
// Parameters:
//   MAX_WAIT    : register-request aging limit in cycles (>= 1); only used
//                 when ULPI_TX_ARB_AGING_EN is defined.
// Ports:
//   ulpi_clk, ulpi_rst_n            : 60 MHz clock, async active-low reset
//   pkt_tvalid/tready/tdata/tlast   : packet requester stream (first byte TX CMD)
//   reg_tvalid/tready/tdata/tlast   : register requester stream
//   tx_tvalid/tready/tdata/tlast    : stream to the ULPI TX engine
//   rx_busy                         : PHY owns the bus (dir high or RX valid)
//   grant_pkt, grant_reg            : current owner, one-hot or both low
//
// Build option:
//   ULPI_TX_ARB_AGING_EN : when defined, a register request that has waited
//                          MAX_WAIT cycles wins a simultaneous arbitration.
//                          Undefined gives strict packet priority.
module ulpi_tx_arbiter
    import ulpi_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic       ulpi_clk,
    input  logic       ulpi_rst_n,

    input  logic       pkt_tvalid,
    output logic       pkt_tready,
    input  logic [7:0] pkt_tdata,
    input  logic       pkt_tlast,

    input  logic       reg_tvalid,
    output logic       reg_tready,
    input  logic [7:0] reg_tdata,
    input  logic       reg_tlast,

    output logic       tx_tvalid,
    input  logic       tx_tready,
    output logic [7:0] tx_tdata,
    output logic       tx_tlast,

    input  logic       rx_busy,

    output logic       grant_pkt,
    output logic       grant_reg
);

    ulpi_arb_state_t state_q;
    ulpi_arb_state_t state_d;
    logic            last_beat;
    logic            reg_promote;

    // ------------------------------------------------------------------
    // Optional aging of the register request
    // ------------------------------------------------------------------
`ifdef ULPI_TX_ARB_AGING_EN
    localparam int unsigned         WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]   WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] reg_wait;

    // Clearing on entry to S_REG takes precedence over the increment that
    // would otherwise happen in the same idle cycle.
    always_ff @(posedge ulpi_clk or negedge ulpi_rst_n) begin
        if (!ulpi_rst_n) begin
            reg_wait <= '0;
        end else if ((state_d == S_REG) && (state_q != S_REG)) begin
            reg_wait <= '0;
        end else if (reg_tvalid && (state_q != S_REG) && (reg_wait != WAIT_MAX)) begin
            reg_wait <= reg_wait + WAIT_W'(1);
        end
    end

    assign reg_promote = (reg_wait == WAIT_MAX);
`else
    logic max_wait_unused;

    assign max_wait_unused = (MAX_WAIT != 0);
    assign reg_promote     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge ulpi_clk or negedge ulpi_rst_n) begin
        if (!ulpi_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Stream routing: purely combinational from the current owner
    // ------------------------------------------------------------------
    always_comb begin
        tx_tvalid  = 1'b0;
        tx_tdata   = '0;
        tx_tlast   = 1'b0;
        pkt_tready = 1'b0;
        reg_tready = 1'b0;
        unique case (state_q)
            S_PKT: begin
                tx_tvalid  = pkt_tvalid;
                tx_tdata   = pkt_tdata;
                tx_tlast   = pkt_tlast;
                pkt_tready = tx_tready;
            end
            S_REG: begin
                tx_tvalid  = reg_tvalid;
                tx_tdata   = reg_tdata;
                tx_tlast   = reg_tlast;
                reg_tready = tx_tready;
            end
            default: begin
            end
        endcase
    end

    assign last_beat = tx_tvalid & tx_tready & tx_tlast;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Owner tvalid gaps and rx_busy during a transfer do not release the
    // grant; only an accepted tlast beat does.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_busy) begin
                    if (pkt_tvalid && !(reg_tvalid && reg_promote)) begin
                        state_d = S_PKT;
                    end else if (reg_tvalid) begin
                        state_d = S_REG;
                    end
                end
            end
            S_PKT, S_REG: begin
                if (last_beat) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign grant_pkt = (state_q == S_PKT);
    assign grant_reg = (state_q == S_REG);

endmodule

// File: tb/tb_ulpi_tx_arbiter.sv
// tb_ulpi_tx_arbiter: directed, table-driven bench for ulpi_tx_arbiter.
// Inputs are driven on the falling edge and outputs sampled 2 ns later.
module tb_ulpi_tx_arbiter;
    import ulpi_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       pkt_tvalid, pkt_tready, pkt_tlast;
    logic [7:0] pkt_tdata;
    logic       reg_tvalid, reg_tready, reg_tlast;
    logic [7:0] reg_tdata;
    logic       tx_tvalid, tx_tready, tx_tlast;
    logic [7:0] tx_tdata;
    logic       rx_busy;
    logic       grant_pkt, grant_reg;

    int total = 0;
    int bad   = 0;

    ulpi_tx_arbiter #(.MAX_WAIT(4)) dut (
        .ulpi_clk   (clk),
        .ulpi_rst_n (rst_n),
        .pkt_tvalid (pkt_tvalid),
        .pkt_tready (pkt_tready),
        .pkt_tdata  (pkt_tdata),
        .pkt_tlast  (pkt_tlast),
        .reg_tvalid (reg_tvalid),
        .reg_tready (reg_tready),
        .reg_tdata  (reg_tdata),
        .reg_tlast  (reg_tlast),
        .tx_tvalid  (tx_tvalid),
        .tx_tready  (tx_tready),
        .tx_tdata   (tx_tdata),
        .tx_tlast   (tx_tlast),
        .rx_busy    (rx_busy),
        .grant_pkt  (grant_pkt),
        .grant_reg  (grant_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rxb;
        logic       pv;
        logic [7:0] pd;
        logic       pl;
        logic       rv;
        logic [7:0] rd;
        logic       rl;
        logic       tr;
        logic       gp;
        logic       gr;
        logic       tv;
        logic [7:0] td;
        logic       tl;
        logic       pr;
        logic       rr;
    } vec_t;

    function automatic vec_t mk(logic rxb, logic pv, logic [7:0] pd, logic pl,
                                logic rv, logic [7:0] rd, logic rl, logic tr,
                                logic gp, logic gr, logic tv, logic [7:0] td,
                                logic tl, logic pr, logic rr);
        vec_t v;
        v.rxb = rxb; v.pv = pv; v.pd = pd; v.pl = pl;
        v.rv = rv; v.rd = rd; v.rl = rl; v.tr = tr;
        v.gp = gp; v.gr = gr; v.tv = tv; v.td = td;
        v.tl = tl; v.pr = pr; v.rr = rr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp_v);
        end
    endtask

    task automatic drive(input vec_t v);
        rx_busy    = v.rxb;
        pkt_tvalid = v.pv; pkt_tdata = v.pd; pkt_tlast = v.pl;
        reg_tvalid = v.rv; reg_tdata = v.rd; reg_tlast = v.rl;
        tx_tready  = v.tr;
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".grant_pkt"},  {7'd0, grant_pkt},  {7'd0, v.gp});
        chk({tag, ".grant_reg"},  {7'd0, grant_reg},  {7'd0, v.gr});
        chk({tag, ".tx_tvalid"},  {7'd0, tx_tvalid},  {7'd0, v.tv});
        chk({tag, ".tx_tdata"},   tx_tdata,           v.td);
        chk({tag, ".tx_tlast"},   {7'd0, tx_tlast},   {7'd0, v.tl});
        chk({tag, ".pkt_tready"}, {7'd0, pkt_tready}, {7'd0, v.pr});
        chk({tag, ".reg_tready"}, {7'd0, reg_tready}, {7'd0, v.rr});
    endtask

    // Drive on the current falling edge, sample, then advance one full cycle.
    task automatic apply(input string tag, input vec_t v);
        drive(v);
        #2;
        check_outs(tag, v);
        @(negedge clk);
    endtask

    vec_t tbl[19];
    vec_t zero_v;
    logic [7:0] regw_84;
    logic [7:0] regr_c4;

    initial begin
        regw_84 = ULPI_TX_CMD_REGW | 8'h04;
        regr_c4 = ULPI_TX_CMD_REGR | 8'h04;
        zero_v  = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0);

        //            rxb pv pd     pl rv rd      rl tr   gp gr tv td     tl pr rr
        // register only: 0x84, 0x55
        tbl[0]  = mk(0, 0, 8'h00, 0, 1, regw_84, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(0, 0, 8'h00, 0, 1, regw_84, 0, 1,  0, 1, 1, 8'h84, 0, 0, 1);
        tbl[2]  = mk(0, 0, 8'h00, 0, 1, 8'h55,   1, 1,  0, 1, 1, 8'h55, 1, 0, 1);
        tbl[3]  = mk(0, 0, 8'h00, 0, 0, 8'h00,   0, 1,  0, 0, 0, 8'h00, 0, 0, 0);
        // simultaneous requests: packet first, one bubble, then register
        tbl[4]  = mk(0, 1, 8'h41, 0, 1, regr_c4, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0);
        tbl[5]  = mk(0, 1, 8'h41, 0, 1, regr_c4, 0, 1,  1, 0, 1, 8'h41, 0, 1, 0);
        tbl[6]  = mk(0, 1, 8'hC3, 0, 1, regr_c4, 0, 1,  1, 0, 1, 8'hC3, 0, 1, 0);
        tbl[7]  = mk(0, 1, 8'h00, 1, 1, regr_c4, 0, 1,  1, 0, 1, 8'h00, 1, 1, 0);
        tbl[8]  = mk(0, 0, 8'h00, 0, 1, regr_c4, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0);
        tbl[9]  = mk(0, 0, 8'h00, 0, 1, regr_c4, 0, 1,  0, 1, 1, 8'hC4, 0, 0, 1);
        // rx_busy for 3 cycles mid-transfer, packet waiting: grant held
        tbl[10] = mk(1, 1, 8'h5A, 0, 1, 8'hAA,   1, 0,  0, 1, 1, 8'hAA, 1, 0, 0);
        tbl[11] = mk(1, 1, 8'h5A, 0, 1, 8'hAA,   1, 0,  0, 1, 1, 8'hAA, 1, 0, 0);
        tbl[12] = mk(1, 1, 8'h5A, 0, 1, 8'hAA,   1, 0,  0, 1, 1, 8'hAA, 1, 0, 0);
        // retry under the same grant, with a tvalid gap before the last byte
        tbl[13] = mk(0, 1, 8'h5A, 0, 1, regr_c4, 0, 1,  0, 1, 1, 8'hC4, 0, 0, 1);
        tbl[14] = mk(0, 1, 8'h5A, 0, 0, 8'hAA,   1, 1,  0, 1, 0, 8'hAA, 1, 0, 1);
        tbl[15] = mk(0, 1, 8'h5A, 0, 1, 8'hAA,   1, 1,  0, 1, 1, 8'hAA, 1, 0, 1);
        // waiting packet taken after the bubble
        tbl[16] = mk(0, 1, 8'h5A, 1, 0, 8'h00,   0, 1,  0, 0, 0, 8'h00, 0, 0, 0);
        tbl[17] = mk(0, 1, 8'h5A, 1, 0, 8'h00,   0, 1,  1, 0, 1, 8'h5A, 1, 1, 0);
        tbl[18] = mk(0, 0, 8'h00, 0, 0, 8'h00,   0, 1,  0, 0, 0, 8'h00, 0, 0, 0);

        // reset state
        rst_n = 1'b0;
        drive(zero_v);
        pkt_tvalid = 1'b1;
        pkt_tdata  = 8'h77;
        #2;
        check_outs("reset", zero_v);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // bus busy: no grant while rx_busy, grant the cycle after it falls
        for (int i = 0; i < 10; i++) begin
            apply($sformatf("busy%0d", i),
                  mk(1, 1, 8'h41, 1, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0));
        end
        apply("busy_fall", mk(0, 1, 8'h41, 1, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0));
        apply("busy_grant", mk(0, 1, 8'h41, 1, 0, 8'h00, 0, 1,  1, 0, 1, 8'h41, 1, 1, 0));
        apply("busy_done", zero_v);

        // reset mid-packet: asynchronous clear, then fresh arbitration
        apply("rst_arb",  mk(0, 1, 8'h11, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0));
        apply("rst_b1",   mk(0, 1, 8'h11, 0, 0, 8'h00, 0, 1,  1, 0, 1, 8'h11, 0, 1, 0));
        drive(mk(0, 1, 8'h22, 0, 0, 8'h00, 0, 1,  1, 0, 1, 8'h22, 0, 1, 0));
        #2;
        chk("rst_b2.grant_pkt", {7'd0, grant_pkt}, 8'd1);
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", mk(0, 1, 8'h22, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        apply("rst_rearb", mk(0, 1, 8'h11, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0, 0));
        apply("rst_regrant", mk(0, 1, 8'h11, 1, 0, 8'h00, 0, 1,  1, 0, 1, 8'h11, 1, 1, 0));
        apply("rst_done", zero_v);

`ifdef ULPI_TX_ARB_AGING_EN
        // aging with MAX_WAIT=4: back-to-back single-byte packets, reg waiting
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply("age0", mk(0, 1, 8'h40, 1, 1, regw_84, 1, 1,  0, 0, 0, 8'h00, 0, 0, 0));
        apply("age1", mk(0, 1, 8'h40, 1, 1, regw_84, 1, 1,  1, 0, 1, 8'h40, 1, 1, 0));
        apply("age2", mk(0, 1, 8'h40, 1, 1, regw_84, 1, 1,  0, 0, 0, 8'h00, 0, 0, 0));
        drive(mk(0, 1, 8'h40, 1, 1, regw_84, 1, 1,  1, 0, 1, 8'h40, 1, 1, 0));
        #2;
        chk("age3.reg_wait", 8'(dut.reg_wait), 8'd3);
        @(negedge clk);
        drive(mk(0, 1, 8'h40, 1, 1, regw_84, 1, 1,  0, 0, 0, 8'h00, 0, 0, 0));
        #2;
        chk("age4.reg_wait", 8'(dut.reg_wait), 8'd4);
        @(negedge clk);
        drive(mk(0, 1, 8'h40, 1, 1, regw_84, 1, 1,  0, 1, 1, 8'h84, 1, 0, 1));
        #2;
        check_outs("age5", mk(0, 1, 8'h40, 1, 1, regw_84, 1, 1,  0, 1, 1, 8'h84, 1, 0, 1));
        chk("age5.reg_wait", 8'(dut.reg_wait), 8'd0);
        @(negedge clk);
        apply("age_done", zero_v);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ulpi_tx_arbiter.md
# ulpi_tx_arbiter

Shares the single ULPI transmit stream between two requesters: the link-layer packet transmitter and the PHY register-access controller. It sits between those requesters and the `ulpi_axis` TX port. Grants are atomic per transfer, with a grant held from first beat to `tlast`. No transfer starts while the PHY owns the bus.

## Interface
- `MAX_WAIT`, default 64: register-request aging limit in cycles; used only with aging compiled in; must be ≥ 1.
- `ulpi_clk` in 1: ULPI 60 MHz clock; all logic is on its rising edge.
- `ulpi_rst_n` in 1: asynchronous, active-low reset.
- `pkt_tvalid` in 1 / `pkt_tready` out 1 / `pkt_tdata` in 8 / `pkt_tlast` in 1: packet requester stream; the first byte is the TX CMD.
- `reg_tvalid` in 1 / `reg_tready` out 1 / `reg_tdata` in 8 / `reg_tlast` in 1: register requester stream (address byte, optional data byte).
- `tx_tvalid` out 1 / `tx_tready` in 1 / `tx_tdata` out 8 / `tx_tlast` out 1: stream to the ULPI TX engine.
- `rx_busy` in 1: PHY is driving the bus (`dir` high or RX stream valid).
- `grant_pkt` out 1 / `grant_reg` out 1: current owner, one-hot or both low.

## Operation
- States are `S_IDLE`, `S_PKT` and `S_REG`. The state is registered.
- **`S_IDLE`**
  - No stream is forwarded.
  - If `rx_busy` is high, the block stays in `S_IDLE`.
  - Otherwise, with only `pkt_tvalid` high, go to `S_PKT`; with only `reg_tvalid` high, go to `S_REG`.
  - With both high, `S_PKT` wins unless aging promotes the register request (see Configuration).
- **`S_PKT` / `S_REG`**
  - The owner's `tvalid`/`tdata`/`tlast` drive `tx_*`.
  - `tx_tready` is routed only to the owner's `tready`.
  - The non-owner's `tready` is 0.
  - Return to `S_IDLE` on the cycle after `tx_tvalid & tx_tready & tx_tlast`.
- The grant is held when the owner deasserts `tvalid` mid-transfer.
- The grant is held when `rx_busy` rises mid-transfer. The TX engine aborts, and the owner retries within the same grant.
- An owner that never sends `tlast` holds the grant indefinitely. This is required behaviour and is not a deadlock check.
- `grant_pkt = (state==S_PKT)` and `grant_reg = (state==S_REG)`.
- In `S_IDLE`: `tx_tvalid` = 0, `tx_tlast` = 0, `tx_tdata` = 0, and both `tready` = 0.

## Timing
- Reset values:
  - state `S_IDLE`
  - `grant_pkt`/`grant_reg` 0
  - `tx_tvalid` 0, `tx_tdata` 0x00, `tx_tlast` 0
  - `pkt_tready`/`reg_tready` 0
  - aging counter 0
- Arbitration latency is one cycle: a request sampled in `S_IDLE` at edge N gives grant and `tx_tvalid` from cycle N+1.
- Data path is combinational once granted: no added latency, no buffering, one byte per cycle at full throughput.
- Back-to-back transfers have exactly one `S_IDLE` bubble cycle between the last beat and the next grant.
- `rx_busy` and a request rising in the same cycle: no grant. The arbiter re-evaluates every cycle in `S_IDLE`.
- Asserting reset mid-transfer clears the grant immediately (asynchronously). Requesters must restart their transfer.

## Configuration
- Macro: `ULPI_TX_ARB_AGING_EN`.
- **Defined**
  - Counter `reg_wait` (width `$clog2(MAX_WAIT+1)`) increments each cycle that `reg_tvalid` is high and `state != S_REG`.
  - It saturates at `MAX_WAIT` and clears on entry to `S_REG`.
  - In `S_IDLE` with both requesting and `reg_wait == MAX_WAIT`, `S_REG` wins.
- **Undefined**
  - Strict packet priority; no counter is instantiated.
  - `MAX_WAIT` is ignored.

## Structure
- `ulpi_pkg` holds the `ulpi_arb_state_t` enum (`S_IDLE`, `S_PKT`, `S_REG`) and the `ULPI_TX_CMD_REGW` / `ULPI_TX_CMD_REGR` byte prefixes used by benches.
- Single module; no sub-module is warranted.

## Test plan
- **Register only:** `reg` sends 0x84 then 0x55 with `tlast`, `tx_tready`=1. Expect `grant_reg` one cycle after `reg_tvalid`, `tx_tdata` 0x84 then 0x55, and `S_IDLE` on the following cycle.
- **Simultaneous requests, aging off:** `pkt` (0x41, 0xC3, 0x00, `tlast`) and `reg` both valid. Expect all 3 packet bytes first, one bubble cycle, then `reg` bytes; `reg_tready` stays 0 throughout the packet.
- **Bus busy:** `rx_busy`=1 for 10 cycles with `pkt_tvalid` high. Expect no grant during those cycles, and `grant_pkt` on the cycle after `rx_busy` falls.
- **Mid-transfer busy:** `rx_busy` pulses for 3 cycles during `S_REG`. Expect `grant_reg` held, and the retried 0xC4 then 0xAA completing under the same grant.
- **Aging (`ULPI_TX_ARB_AGING_EN`, `MAX_WAIT`=4):** continuous packets with `reg` waiting. Expect `reg` granted at the first `S_IDLE` after 4 waiting cycles, and `reg_wait` cleared to 0.
- **Reset mid-packet:** assert `ulpi_rst_n`=0 during the second byte. Expect all outputs at reset values before the next edge, and a fresh arbitration after release.
